cp0_exc_unit: RTL

Parametrised successor to the M-stage exception classifier. It merges exception prioritisation with the CP0 state it depends on: Status, Cause, EPC, BadVAddr and Count/Compare. It also adds synchronised external interrupt lines, ERET handling and a configurable timer interrupt. It sits in the memory stage and supplies flush and redirect to the hazard unit and fetch stage.

---
 rtl/cp0_exc_unit.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/cp0_exc_unit.sv
// M-stage exception classifier merged with CP0 Status/Cause/EPC/BadVAddr/Count/Compare.
// Define CP0_TIMER_INT_EN to enable the Count/Compare timer interrupt on Cause.IP[15].
module cp0_exc_unit #(
  parameter int          N_HW_INT     = 6,
  parameter int          SYNC_STAGES  = 2,
  parameter logic [31:0] RESET_PC_VEC = 32'hBFC0_0380
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [N_HW_INT-1:0] ext_int,
  input  logic                instM_valid,
  input  logic                stallM,
  input  logic                in_delayslotM,
  input  logic                pc_error,
  input  logic                addr_error_lw,
  input  logic                addr_error_sw,
  input  logic                sys,
  input  logic                bp,
  input  logic                ri,
  input  logic                ov,
  input  logic                eretM,
  input  logic [31:0]         pcM,
  input  logic [31:0]         ALUOutM,
  input  logic                cp0_we,
  input  logic [4:0]          cp0_waddr,
  input  logic [4:0]          cp0_raddr,
  input  logic [31:0]         cp0_wdata,
  output logic [31:0]         cp0_rdata,
  output logic [4:0]          exception_code,
  output logic                exception_flush,
  output logic                pc_trap,
  output logic [31:0]         trap_target,
  output logic [31:0]         status_o,
  output logic [31:0]         cause_o,
  output logic [31:0]         epc_o
);

  localparam logic [4:0]  EXC_NONE     = 5'b11111;
  localparam logic [31:0] STATUS_RST   = 32'h0040_0000;
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  logic [31:0]         status_q, epc_q, badvaddr_q, count_q, compare_q;
  logic                cause_bd_q;
  logic [1:0]          cause_sw_ip_q;
  logic [N_HW_INT-1:0] cause_hw_ip_q;
  logic [4:0]          cause_exc_q;
  logic [N_HW_INT-1:0] sync_p [SYNC_STAGES];
  logic                cause_ti;
`ifdef CP0_TIMER_INT_EN
  logic                tick_q;
`endif

  logic [5:0]  hw_ip;
  logic [7:0]  ip_all;
  logic [31:0] cause_rd;
  logic        int_pending;
  logic [4:0]  exc_code;
  logic        exc_take, eret_take;

  // Fixed priority: interrupt, pc_error, ri, ov, bp, sys, load/store address error.
  function automatic logic [4:0] exc_encode(
    input logic valid, input logic intr, input logic pc_err, input logic ri_f,
    input logic ov_f, input logic bp_f, input logic sys_f, input logic adel,
    input logic ades
  );
    if (!valid)  return EXC_NONE;
    if (intr)    return 5'd0;
    if (pc_err)  return 5'd4;
    if (ri_f)    return 5'd10;
    if (ov_f)    return 5'd12;
    if (bp_f)    return 5'd9;
    if (sys_f)   return 5'd8;
    if (adel)    return 5'd4;
    if (ades)    return 5'd5;
    return EXC_NONE;
  endfunction

  // IP[15:10] view: synced hardware lines, with the timer OR-ed into IP[15].
  always_comb begin
    hw_ip = '0;
    hw_ip[N_HW_INT-1:0] = cause_hw_ip_q;
    hw_ip[5] = hw_ip[5] | cause_ti;
  end

  assign ip_all   = {hw_ip, cause_sw_ip_q};
  assign cause_rd = {cause_bd_q, cause_ti, 14'b0, ip_all, 1'b0, cause_exc_q, 2'b00};

  assign int_pending = status_q[0] & ~status_q[1] & (|(status_q[15:8] & ip_all));

  // Reset gates the classifier so outputs go idle the moment resetn drops.
  assign exc_code  = exc_encode(instM_valid & resetn, int_pending, pc_error, ri, ov,
                                bp, sys, addr_error_lw, addr_error_sw);
  assign exc_take  = (exc_code != EXC_NONE);
  assign eret_take = instM_valid & resetn & eretM & ~exc_take;

  assign exception_code  = exc_code;
  assign exception_flush = exc_take | eret_take;
  assign pc_trap         = exc_take | eret_take;
  assign trap_target     = eret_take ? epc_q : RESET_PC_VEC;

  assign status_o = status_q;
  assign cause_o  = cause_rd;
  assign epc_o    = epc_q;

  always_comb begin
    cp0_rdata = '0;
    case (cp0_raddr)
      REG_BADVADDR: cp0_rdata = badvaddr_q;
      REG_COUNT:    cp0_rdata = count_q;
      REG_COMPARE:  cp0_rdata = compare_q;
      REG_STATUS:   cp0_rdata = status_q;
      REG_CAUSE:    cp0_rdata = cause_rd;
      REG_EPC:      cp0_rdata = epc_q;
      default:      cp0_rdata = '0;
    endcase
  end

`ifndef CP0_TIMER_INT_EN
  assign cause_ti = 1'b0;
`endif

  // CP0 state commit: later assignments take precedence (MTC0 < ERET < exception).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      status_q      <= STATUS_RST;
      epc_q         <= '0;
      badvaddr_q    <= '0;
      count_q       <= '0;
      compare_q     <= '0;
      cause_bd_q    <= 1'b0;
      cause_sw_ip_q <= '0;
      cause_hw_ip_q <= '0;
      cause_exc_q   <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= '0;
`ifdef CP0_TIMER_INT_EN
      tick_q        <= 1'b0;
      cause_ti      <= 1'b0;
`endif
    end else if (!stallM) begin
      sync_p[0] <= ext_int;
      for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
      cause_hw_ip_q <= sync_p[SYNC_STAGES-1];
`ifdef CP0_TIMER_INT_EN
      tick_q <= ~tick_q;
      if (tick_q) count_q <= count_q + 32'd1;
      if ((count_q == compare_q) && (compare_q != '0)) cause_ti <= 1'b1;
`endif
      if (cp0_we) begin
        case (cp0_waddr)
          REG_STATUS:  status_q <= (status_q & ~STATUS_WMASK) | (cp0_wdata & STATUS_WMASK);
          REG_CAUSE:   cause_sw_ip_q <= cp0_wdata[9:8];
          REG_EPC:     epc_q <= cp0_wdata;
          REG_COUNT:   count_q <= cp0_wdata;
          REG_COMPARE: begin
            compare_q <= cp0_wdata;
`ifdef CP0_TIMER_INT_EN
            cause_ti  <= 1'b0;
`endif
          end
          default: ;
        endcase
      end
      if (eret_take) status_q[1] <= 1'b0;
      if (exc_take) begin
        epc_q       <= in_delayslotM ? (pcM - 32'd4) : pcM;
        cause_bd_q  <= in_delayslotM;
        cause_exc_q <= exc_code;
        status_q[1] <= 1'b1;
        if ((exc_code == 5'd4) || (exc_code == 5'd5))
          badvaddr_q <= pc_error ? pcM : ALUOutM;
      end
    end
  end

endmodule
